// File: rtl/mempool_tcdm_rob.sv
// Reorder buffer between a core TCDM port and memory. Requests are tagged with
// a slot index, out-of-order responses are parked in their slot, and retired in issue order.
package snitch_pkg;
    typedef logic [7:0] meta_id_t;
endpackage

module mempool_tcdm_rob #(
    parameter int  NumEntries = 8,
    parameter int  DataWidth  = 32,
    parameter type meta_id_t  = snitch_pkg::meta_id_t,
    localparam int IdxWidth   = $clog2(NumEntries)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // Core request
    input  logic [31:0]            core_qaddr_i,
    input  logic                   core_qwrite_i,
    input  logic [3:0]             core_qamo_i,
    input  logic [DataWidth-1:0]   core_qdata_i,
    input  logic [DataWidth/8-1:0] core_qstrb_i,
    input  meta_id_t               core_qid_i,
    input  logic                   core_qvalid_i,
    output logic                   core_qready_o,
    // Core response
    output logic [DataWidth-1:0]   core_pdata_o,
    output logic                   core_perror_o,
    output meta_id_t               core_pid_o,
    output logic                   core_pvalid_o,
    input  logic                   core_pready_i,
    // Memory request
    output logic [31:0]            mem_qaddr_o,
    output logic                   mem_qwrite_o,
    output logic [3:0]             mem_qamo_o,
    output logic [DataWidth-1:0]   mem_qdata_o,
    output logic [DataWidth/8-1:0] mem_qstrb_o,
    output logic [IdxWidth-1:0]    mem_qid_o,
    output logic                   mem_qvalid_o,
    input  logic                   mem_qready_i,
    // Memory response
    input  logic [DataWidth-1:0]   mem_pdata_i,
    input  logic                   mem_perror_i,
    input  logic [IdxWidth-1:0]    mem_pid_i,
    input  logic                   mem_pvalid_i,
    output logic                   mem_pready_o,
    // Occupancy, for observation only
    output logic [IdxWidth:0]      dbg_count_o
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never waits on ready, and the request path is purely
    // combinational from core to memory.

    localparam logic [IdxWidth:0]   FullCount = (IdxWidth+1)'(NumEntries);
    localparam logic [IdxWidth:0]   CntOne    = (IdxWidth+1)'(1);
    localparam logic [IdxWidth-1:0] PtrOne    = IdxWidth'(1);

    logic [NumEntries-1:0] r_busy;
    logic [NumEntries-1:0] r_done;
    logic [NumEntries-1:0] r_err;
    logic [DataWidth-1:0]  r_data [NumEntries];
    meta_id_t              r_id   [NumEntries];
    logic [IdxWidth-1:0]   r_alloc_ptr;
    logic [IdxWidth-1:0]   r_retire_ptr;
    logic [IdxWidth:0]     r_count;
    logic                  r_pready;

    logic w_full;
    logic w_alloc;
    logic w_retire;
    logic w_resp_ok;

    // Full is taken from the registered count, so a retire in the same cycle
    // only frees a slot for allocation from the following cycle on.
    assign w_full        = (r_count == FullCount);
    assign mem_qvalid_o  = core_qvalid_i & ~w_full;
    assign core_qready_o = mem_qready_i & ~w_full;
    assign w_alloc       = mem_qvalid_o & mem_qready_i;

    assign mem_qaddr_o  = core_qaddr_i;
    assign mem_qwrite_o = core_qwrite_i;
    assign mem_qamo_o   = core_qamo_i;
    assign mem_qdata_o  = core_qdata_i;
    assign mem_qstrb_o  = core_qstrb_i;
    assign mem_qid_o    = r_alloc_ptr;

    assign mem_pready_o = r_pready;
    assign w_resp_ok    = mem_pvalid_i & r_busy[mem_pid_i] & ~r_done[mem_pid_i];

    assign core_pvalid_o = r_busy[r_retire_ptr] & r_done[r_retire_ptr];
    assign core_pdata_o  = r_data[r_retire_ptr];
    assign core_perror_o = r_err[r_retire_ptr];
    assign core_pid_o    = r_id[r_retire_ptr];
    assign w_retire      = core_pvalid_o & core_pready_i;

    assign dbg_count_o = r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pready <= 1'b0;
        end else begin
            r_pready <= 1'b1;
        end
    end

    // Alloc, response and retire never target the same slot in one cycle:
    // the alloc slot is free, a response needs a busy non-done slot, and
    // the retiring slot is already done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
            r_done <= '0;
            r_err  <= '0;
            for (int i = 0; i < NumEntries; i++) begin
                r_data[i] <= '0;
                r_id[i]   <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_busy[r_alloc_ptr] <= 1'b1;
                r_done[r_alloc_ptr] <= 1'b0;
                r_id[r_alloc_ptr]   <= core_qid_i;
            end
            if (w_resp_ok) begin
                r_done[mem_pid_i] <= 1'b1;
                r_err[mem_pid_i]  <= mem_perror_i;
                r_data[mem_pid_i] <= mem_pdata_i;
            end
            if (w_retire) begin
                r_busy[r_retire_ptr] <= 1'b0;
                r_done[r_retire_ptr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alloc_ptr  <= '0;
            r_retire_ptr <= '0;
            r_count      <= '0;
        end else begin
            if (w_alloc) begin
                r_alloc_ptr <= r_alloc_ptr + PtrOne;
            end
            if (w_retire) begin
                r_retire_ptr <= r_retire_ptr + PtrOne;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // A response must target an outstanding slot that has not answered yet.
    resp_target_valid_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_pvalid_i |-> (r_busy[mem_pid_i] && !r_done[mem_pid_i]));

    resp_not_alloc_slot_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_alloc && mem_pvalid_i && (mem_pid_i == r_alloc_ptr)));

endmodule

// File: tb/tb_mempool_tcdm_rob.sv
// Bench for mempool_tcdm_rob: request-path vector table, directed ordering
// scenarios, and a randomized run against an issue-order queue model.
module tb_mempool_tcdm_rob;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int IW = 3;
    typedef snitch_pkg::meta_id_t id_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   core_qaddr = '0;
    logic          core_qwrite = 1'b0;
    logic [3:0]    core_qamo = '0;
    logic [DW-1:0] core_qdata = '0;
    logic [3:0]    core_qstrb = '0;
    id_t           core_qid = '0;
    logic          core_qvalid = 1'b0;
    logic          core_qready_o;
    logic [DW-1:0] core_pdata_o;
    logic          core_perror_o;
    id_t           core_pid_o;
    logic          core_pvalid_o;
    logic          core_pready = 1'b1;
    logic [31:0]   mem_qaddr_o;
    logic          mem_qwrite_o;
    logic [3:0]    mem_qamo_o;
    logic [DW-1:0] mem_qdata_o;
    logic [3:0]    mem_qstrb_o;
    logic [IW-1:0] mem_qid_o;
    logic          mem_qvalid_o;
    logic          mem_qready = 1'b1;
    logic [DW-1:0] mem_pdata = '0;
    logic          mem_perror = 1'b0;
    logic [IW-1:0] mem_pid = '0;
    logic          mem_pvalid = 1'b0;
    logic          mem_pready_o;
    logic [IW:0]   dbg_count_o;

    always #5 clk = ~clk;

    mempool_tcdm_rob dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_qaddr_i(core_qaddr), .core_qwrite_i(core_qwrite), .core_qamo_i(core_qamo),
        .core_qdata_i(core_qdata), .core_qstrb_i(core_qstrb), .core_qid_i(core_qid),
        .core_qvalid_i(core_qvalid), .core_qready_o(core_qready_o),
        .core_pdata_o(core_pdata_o), .core_perror_o(core_perror_o), .core_pid_o(core_pid_o),
        .core_pvalid_o(core_pvalid_o), .core_pready_i(core_pready),
        .mem_qaddr_o(mem_qaddr_o), .mem_qwrite_o(mem_qwrite_o), .mem_qamo_o(mem_qamo_o),
        .mem_qdata_o(mem_qdata_o), .mem_qstrb_o(mem_qstrb_o), .mem_qid_o(mem_qid_o),
        .mem_qvalid_o(mem_qvalid_o), .mem_qready_i(mem_qready),
        .mem_pdata_i(mem_pdata), .mem_perror_i(mem_perror), .mem_pid_i(mem_pid),
        .mem_pvalid_i(mem_pvalid), .mem_pready_o(mem_pready_o),
        .dbg_count_o(dbg_count_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    id_t           exp_id_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        core_qvalid = 1'b0;
        mem_pvalid  = 1'b0;
        mem_qready  = 1'b1;
        core_pready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        exp_q.delete();
        exp_id_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, returns the slot id seen on mem_qid_o, completes at edge+1.
    task automatic issue(input id_t id, output logic [IW-1:0] slot);
        core_qvalid = 1'b1;
        core_qid    = id;
        core_qaddr  = $urandom;
        core_qwrite = 1'($urandom_range(0, 1));
        core_qamo   = 4'($urandom_range(0, 15));
        core_qdata  = $urandom;
        core_qstrb  = 4'hF;
        mem_qready  = 1'b1;
        #1;
        check("issue_qready", core_qready_o, 1);
        slot = mem_qid_o;
        @(posedge clk);
        #1;
        core_qvalid = 1'b0;
    endtask

    task automatic respond(input logic [IW-1:0] slot, input logic [DW-1:0] data, input logic err);
        mem_pvalid = 1'b1;
        mem_pid    = slot;
        mem_pdata  = data;
        mem_perror = err;
        @(posedge clk);
        #1;
        mem_pvalid = 1'b0;
    endtask

    task automatic expect_head(input string name);
        check({name, "_pvalid"}, core_pvalid_o, 1);
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            check({name, "_pdata"}, core_pdata_o, exp_q.pop_front());
            check({name, "_pid"}, core_pid_o, exp_id_q.pop_front());
        end
    endtask

    typedef struct {
        logic          qv;
        logic          mr;
        logic [31:0]   addr;
        logic          wr;
        logic [3:0]    amo;
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic          exp_mv;
        logic          exp_cr;
        logic [IW-1:0] exp_qid;
    } vec_t;

    typedef struct {
        id_t           id;
        logic [IW-1:0] slot;
        logic          done;
        logic [DW-1:0] data;
        logic          err;
    } txn_t;

    initial begin
        vec_t vecs[6];
        logic [IW-1:0] s;
        logic [DW-1:0] d;
        txn_t mq[$];
        int alloc_n;

        vecs[0] = '{1'b0, 1'b0, $urandom, 1'b0, 4'h0, $urandom, 4'h1, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 1'b0, $urandom, 1'b1, 4'h3, $urandom, 4'h3, 1'b1, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 1'b1, $urandom, 1'b0, 4'h7, $urandom, 4'h7, 1'b0, 1'b1, 3'd0};
        vecs[3] = '{1'b1, 1'b1, $urandom, 1'b1, 4'hA, $urandom, 4'hF, 1'b1, 1'b1, 3'd0};
        vecs[4] = '{1'b1, 1'b1, $urandom, 1'b0, 4'h5, $urandom, 4'h8, 1'b1, 1'b1, 3'd1};
        vecs[5] = '{1'b1, 1'b0, $urandom, 1'b1, 4'hF, $urandom, 4'hC, 1'b1, 1'b0, 3'd2};

        // Values while reset is held
        idle();
        core_qvalid = 1'b1;
        #1;
        check("rst_pvalid", core_pvalid_o, 0);
        check("rst_pready", mem_pready_o, 0);
        check("rst_count", dbg_count_o, 0);
        check("rst_pdata", core_pdata_o, 0);
        check("rst_pid", core_pid_o, 0);
        check("rst_qready", core_qready_o, 1);
        check("rst_mqvalid", mem_qvalid_o, 1);
        check("rst_qid", mem_qid_o, 0);
        core_qvalid = 1'b0;
        do_reset();
        check("post_rst_pready", mem_pready_o, 1);

        // Request-path vector table
        for (int i = 0; i < 6; i++) begin
            core_qvalid = vecs[i].qv;
            mem_qready  = vecs[i].mr;
            core_qaddr  = vecs[i].addr;
            core_qwrite = vecs[i].wr;
            core_qamo   = vecs[i].amo;
            core_qdata  = vecs[i].data;
            core_qstrb  = vecs[i].strb;
            core_qid    = id_t'(i);
            #1;
            check("vec_mqvalid", mem_qvalid_o, vecs[i].exp_mv);
            check("vec_qready", core_qready_o, vecs[i].exp_cr);
            check("vec_qid", mem_qid_o, vecs[i].exp_qid);
            check("vec_addr", mem_qaddr_o, vecs[i].addr);
            check("vec_write", mem_qwrite_o, vecs[i].wr);
            check("vec_amo", mem_qamo_o, vecs[i].amo);
            check("vec_data", mem_qdata_o, vecs[i].data);
            check("vec_strb", mem_qstrb_o, vecs[i].strb);
            @(posedge clk);
            #1;
        end
        check("vec_count", dbg_count_o, 2);

        // In-order loads with core IDs 5,6,7
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(id_t'(5 + i), s);
            check("inorder_qid", s, i);
        end
        check("inorder_idle", core_pvalid_o, 0);
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            respond(IW'(i), d, 1'b0);
            exp_q.push_back(d);
            exp_id_q.push_back(id_t'(5 + i));
            expect_head("inorder");
        end
        @(posedge clk);
        #1;
        check("inorder_drained", core_pvalid_o, 0);
        check("inorder_count", dbg_count_o, 0);

        // Reordered responses 3,1,0,2
        do_reset();
        for (int i = 0; i < 4; i++) issue(id_t'(10 + i), s);
        respond(3'd3, 32'hD3, 1'b0);
        check("reorder_wait3", core_pvalid_o, 0);
        respond(3'd1, 32'hD1, 1'b0);
        check("reorder_wait1", core_pvalid_o, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hD0 + 32'(i));
            exp_id_q.push_back(id_t'(10 + i));
        end
        respond(3'd0, 32'hD0, 1'b0);
        expect_head("reorder");
        respond(3'd2, 32'hD2, 1'b0);
        expect_head("reorder");
        @(posedge clk);
        #1;
        expect_head("reorder");
        @(posedge clk);
        #1;
        expect_head("reorder");
        @(posedge clk);
        #1;
        check("reorder_drained", core_pvalid_o, 0);

        // Full ROB, retire does not unblock in the same cycle
        do_reset();
        core_pready = 1'b0;
        for (int i = 0; i < N; i++) issue(id_t'(i), s);
        core_qvalid = 1'b1;
        #1;
        check("full_qready", core_qready_o, 0);
        check("full_mqvalid", mem_qvalid_o, 0);
        check("full_count", dbg_count_o, N);
        d = $urandom;
        respond(3'd0, d, 1'b0);
        check("full_head", core_pdata_o, d);
        core_pready = 1'b1;
        #1;
        check("full_same_cycle_qready", core_qready_o, 0);
        check("full_same_cycle_mqvalid", mem_qvalid_o, 0);
        @(posedge clk);
        #1;
        check("full_next_qready", core_qready_o, 1);
        check("full_next_mqvalid", mem_qvalid_o, 1);
        check("full_next_qid", mem_qid_o, 0);
        check("full_next_count", dbg_count_o, N - 1);
        @(posedge clk);
        #1;
        core_qvalid = 1'b0;
        check("full_refill_count", dbg_count_o, N);

        // 20 request/response pairs wrapping the slot index
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(id_t'(i), s);
            check("wrap_qid", s, i % N);
            d = $urandom;
            respond(s, d, 1'b0);
            exp_q.push_back(d);
            exp_id_q.push_back(id_t'(i));
            expect_head("wrap");
        end
        @(posedge clk);
        #1;
        check("wrap_drained", core_pvalid_o, 0);

        // Back-pressure with an error response at the head
        do_reset();
        core_pready = 1'b0;
        issue(id_t'(20), s);
        issue(id_t'(21), s);
        respond(3'd0, 32'hBAD0_0001, 1'b1);
        d = $urandom;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                mem_pvalid = 1'b1;
                mem_pid    = 3'd1;
                mem_pdata  = d;
                mem_perror = 1'b0;
            end
            check("bp_pvalid", core_pvalid_o, 1);
            check("bp_pdata", core_pdata_o, 32'hBAD0_0001);
            check("bp_perror", core_perror_o, 1);
            check("bp_pid", core_pid_o, 20);
            @(posedge clk);
            #1;
            mem_pvalid = 1'b0;
        end
        core_pready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_next_pvalid", core_pvalid_o, 1);
        check("bp_next_pdata", core_pdata_o, d);
        check("bp_next_perror", core_perror_o, 0);
        check("bp_next_pid", core_pid_o, 21);
        @(posedge clk);
        #1;
        check("bp_drained", core_pvalid_o, 0);

        // Reset in the middle of outstanding traffic
        do_reset();
        core_pready = 1'b0;
        for (int i = 0; i < 3; i++) issue(id_t'(40 + i), s);
        respond(3'd0, 32'h1234_5678, 1'b0);
        check("midrst_pre_pvalid", core_pvalid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pvalid", core_pvalid_o, 0);
        check("midrst_count", dbg_count_o, 0);
        check("midrst_pdata", core_pdata_o, 0);
        check("midrst_pid", core_pid_o, 0);
        check("midrst_pready", mem_pready_o, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        issue(id_t'(50), s);
        check("midrst_first_qid", s, 0);

        // Randomized traffic against an issue-order queue model
        do_reset();
        alloc_n = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic qv, mr, pr, full, exp_pv;
            int ridx;
            int cand[$];
            qv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 2) != 0);
            ridx = -1;
            cand.delete();
            for (int j = 0; j < mq.size(); j++) if (!mq[j].done) cand.push_back(j);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                ridx = cand[$urandom_range(0, cand.size() - 1)];
            end
            core_qvalid = qv;
            mem_qready  = mr;
            core_pready = pr;
            core_qid    = id_t'($urandom);
            core_qaddr  = $urandom;
            if (ridx >= 0) begin
                mem_pvalid = 1'b1;
                mem_pid    = mq[ridx].slot;
                mem_pdata  = $urandom;
                mem_perror = 1'($urandom_range(0, 1));
            end else begin
                mem_pvalid = 1'b0;
            end
            #1;
            full   = (mq.size() == N);
            exp_pv = (mq.size() > 0) && mq[0].done;
            check("rnd_qready", core_qready_o, mr && !full);
            check("rnd_mqvalid", mem_qvalid_o, qv && !full);
            check("rnd_qid", mem_qid_o, alloc_n % N);
            check("rnd_addr", mem_qaddr_o, core_qaddr);
            check("rnd_pvalid", core_pvalid_o, exp_pv);
            if (exp_pv) begin
                check("rnd_pdata", core_pdata_o, mq[0].data);
                check("rnd_pid", core_pid_o, mq[0].id);
                check("rnd_perror", core_perror_o, mq[0].err);
            end
            @(posedge clk);
            #1;
            if (ridx >= 0) begin
                mq[ridx].done = 1'b1;
                mq[ridx].data = mem_pdata;
                mq[ridx].err  = mem_perror;
            end
            if (exp_pv && pr) void'(mq.pop_front());
            if (qv && mr && !full) begin
                mq.push_back('{core_qid, IW'(alloc_n % N), 1'b0, '0, 1'b0});
                alloc_n++;
            end
            mem_pvalid = 1'b0;
        end
        check("rnd_final_count", dbg_count_o, mq.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mempool_tcdm_rob.md
MEMPOOL_TCDM_ROB -- requirements
Module: mempool_tcdm_rob

Interface
REQ-001 SHALL have parameter NumEntries, default 8, ROB depth; power of two, at least 2.
REQ-002 SHALL have parameter DataWidth, default 32, data width in bits.
REQ-003 SHALL have parameter type meta_id_t, default snitch_pkg::meta_id_t, core-side transaction ID.
REQ-004 SHALL derive localparam IdxWidth = $clog2(NumEntries); memory-side ID equals slot index.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-006 Core request ports: core_qaddr_i in 32; core_qwrite_i in 1; core_qamo_i in 4; core_qdata_i in DataWidth; core_qstrb_i in DataWidth/8; core_qid_i in meta_id_t; core_qvalid_i in 1; core_qready_o out 1.
REQ-007 Core response ports: core_pdata_o out DataWidth; core_perror_o out 1; core_pid_o out meta_id_t; core_pvalid_o out 1; core_pready_i in 1.
REQ-008 Memory request ports: mem_qaddr_o out 32; mem_qwrite_o out 1; mem_qamo_o out 4; mem_qdata_o out DataWidth; mem_qstrb_o out DataWidth/8; mem_qid_o out IdxWidth; mem_qvalid_o out 1; mem_qready_i in 1.
REQ-009 Memory response ports: mem_pdata_i in DataWidth; mem_perror_i in 1; mem_pid_i in IdxWidth; mem_pvalid_i in 1; mem_pready_o out 1.

Function
REQ-010 SHALL sit downstream of the core complex TCDM port, issue requests with slot-index IDs, accept out-of-order responses, and return responses to the core in issue order.
REQ-011 SHALL hold per slot: busy, done, error, data, core ID; alloc pointer, retire pointer, and a count of width IdxWidth+1.
REQ-012 Request path SHALL be combinational: addr/write/amo/data/strb forwarded unchanged; mem_qid_o = alloc pointer.
REQ-013 mem_qvalid_o SHALL equal core_qvalid_i AND NOT full; core_qready_o SHALL equal mem_qready_i AND NOT full.
REQ-014 Full SHALL mean count == NumEntries; a retire in the same cycle SHALL NOT unblock allocation.
REQ-015 On mem_qvalid_o AND mem_qready_i, the block SHALL set busy, clear done, store core_qid_i in the alloc slot, and increment the alloc pointer modulo NumEntries.
REQ-016 Every request, read, write, or AMO, SHALL allocate a slot and expect exactly one response.
REQ-017 mem_pready_o SHALL be constant 1 after reset; slots are pre-reserved, so responses are never back-pressured.
REQ-018 On mem_pvalid_i, the block SHALL write data and error into slot mem_pid_i and set done, if that slot is busy and not done.
REQ-019 A response to a non-busy or already-done slot SHALL be dropped with no state change, and SHALL be flagged by a simulation-only assertion.
REQ-020 core_pvalid_o SHALL equal busy AND done of the retire slot; core_pdata_o, core_perror_o and core_pid_o SHALL come from that slot, registered only.
REQ-021 Minimum latency SHALL be 1 cycle from a mem response for the head slot to core_pvalid_o; there is no combinational mem_p to core_p path.
REQ-022 On core_pvalid_o AND core_pready_i, the block SHALL clear busy and done of the retire slot and increment the retire pointer modulo NumEntries.
REQ-023 Count SHALL increment on alloc only, decrement on retire only, and stay unchanged when both occur in one cycle.
REQ-024 Response outputs SHALL stay stable while core_pvalid_o=1 and core_pready_i=0.
REQ-025 A response for the alloc slot arriving in the same cycle as that slot's allocation is illegal, and SHALL be flagged by a simulation-only assertion.

Reset
REQ-026 On rst_ni=0, asynchronously: all busy/done/error cleared; pointers and count 0; core_pvalid_o=0; core_pdata_o=0; core_pid_o=0.
REQ-027 Reset mid-operation SHALL discard all outstanding transactions; late responses after reset are dropped per REQ-019.
REQ-028 During reset, mem_pready_o SHALL be 0; core_qready_o and mem_qvalid_o follow REQ-013 with count=0.

Verification
REQ-029 Scenario in-order: issue 3 loads (core IDs 5,6,7), respond IDs 0,1,2 in order -> core sees IDs 5,6,7 with matching data, each 1 cycle after its response.
REQ-030 Scenario reorder: issue 4 requests, respond in order 3,1,0,2 with data 0xD3,0xD1,0xD0,0xD2 -> nothing returned until slot 0 is done, then 0xD0,0xD1,0xD2,0xD3 on consecutive cycles with core_pready_i=1.
REQ-031 Scenario full: with NumEntries=8 and no responses, 8 handshakes -> core_qready_o=0 and mem_qvalid_o=0; retiring one slot re-enables allocation on the next cycle, not the same cycle.
REQ-032 Scenario wrap: 20 sequential request/response pairs -> mem_qid_o sequence 0..7,0..7,0..3 and all data returned in order.
REQ-033 Scenario back-pressure: core_pready_i=0 for 5 cycles with head done -> outputs stable; error bit of a response with mem_perror_i=1 propagates to core_perror_o=1.
REQ-034 Scenario reset mid-op: 3 outstanding requests, assert rst_ni=0 -> core_pvalid_o=0, count=0; after release, first request uses mem_qid_o=0.
